// File: rtl/mem_responder.sv
// Word-addressed memory responder: clears its array after reset, then serves
// single-cycle writes and fixed-latency pipelined reads, flagging bad requests.
module mem_responder #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        write,
   input  logic        read,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        rd_uninit,
   output logic        err,
   output logic [15:0] wr_cnt,
   output logic [15:0] rd_cnt
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned LAST = RD_LAT - 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_idx;
   logic [31:0]     r_mem [DEPTH];
   logic [DEPTH-1:0] r_wflag;

   // read pipeline: one stage per cycle of latency before the output register
   logic            r_pv [RD_LAT];
   logic [31:0]     r_pd [RD_LAT];
   logic            r_pu [RD_LAT];

   logic            w_req;
   logic            w_oob;
   logic            w_bad;
   logic            w_wr;
   logic            w_rd;
   logic [AW-1:0]   w_idx;

   assign w_idx = addr[AW-1:0];
   assign w_oob = (addr >= 32'(DEPTH));
   assign w_req = ready & (write | read);
   assign w_bad = w_req & ((write & read) | w_oob);
   assign w_wr  = ready & write & ~read & ~w_oob;
   assign w_rd  = ready & read & ~write & ~w_oob;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_INIT;
         r_idx     <= '0;
         ready     <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         rd_uninit <= 1'b0;
         err       <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         for (int k = 0; k < int'(RD_LAT); k++) begin
            r_pv[k] <= 1'b0;
            r_pu[k] <= 1'b0;
            r_pd[k] <= '0;
         end
      end else begin
         err <= w_bad;

         r_pv[0] <= w_rd;
         r_pd[0] <= w_rd ? r_mem[w_idx] : 32'd0;
         r_pu[0] <= w_rd & ~r_wflag[w_idx];
         for (int k = 1; k < int'(RD_LAT); k++) begin
            r_pv[k] <= r_pv[k-1];
            r_pd[k] <= r_pd[k-1];
            r_pu[k] <= r_pu[k-1];
         end

         // data and uninit are forced low whenever no read completes
         rvalid    <= r_pv[LAST];
         rdata     <= r_pv[LAST] ? r_pd[LAST] : 32'd0;
         rd_uninit <= r_pv[LAST] & r_pu[LAST];

         case (r_state)
            ST_INIT: begin
               r_mem[r_idx]   <= '0;
               r_wflag[r_idx] <= 1'b0;
               if (r_idx == AW'(DEPTH - 1)) begin
                  r_state <= ST_RUN;
                  ready   <= 1'b1;
               end else begin
                  r_idx <= r_idx + AW'(1);
               end
            end
            ST_RUN: begin
               ready <= 1'b1;
               if (w_wr) begin
                  r_mem[w_idx]   <= wdata;
                  r_wflag[w_idx] <= 1'b1;
                  wr_cnt         <= wr_cnt + 16'd1;
               end
               if (w_rd) begin
                  rd_cnt <= rd_cnt + 16'd1;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; read results are tracked by a scoreboard
// queue holding expected data, uninit flag and the cycle the result is due.
module tb_mem_responder;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned RD_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        write;
   logic        read;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rd_uninit;
   logic        err;
   logic [15:0] wr_cnt;
   logic [15:0] rd_cnt;

   typedef struct {
      logic [31:0] d;
      logic        u;
      int          due;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   int   cyc   = 0;

   mem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .write(write), .read(read), .addr(addr),
      .wdata(wdata), .ready(ready), .rdata(rdata), .rvalid(rvalid),
      .rd_uninit(rd_uninit), .err(err), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock, then check the read response port against the scoreboard
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (rvalid === 1'b1) begin
         if (q.size() == 0) begin
            chk("rvalid_unexpected", 32'(rvalid), 32'd0);
         end else begin
            e = q.pop_front();
            chk("rd_due_cycle", 32'(cyc), 32'(e.due));
            chk("rdata", rdata, e.d);
            chk("rd_uninit", 32'(rd_uninit), 32'(e.u));
         end
      end else begin
         chk("idle_rdata", rdata, 32'd0);
         chk("idle_uninit", 32'(rd_uninit), 32'd0);
         if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("rvalid_missing", 32'(rvalid), 32'd1);
         end
      end
   endtask

   task automatic idle();
      write = 1'b0;
      read  = 1'b0;
      addr  = '0;
      wdata = '0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      write = 1'b1; read = 1'b0; addr = a; wdata = d;
      tick();
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic u);
      exp_t e;
      write = 1'b0; read = 1'b1; addr = a;
      e.d = d; e.u = u; e.due = cyc + 1 + int'(RD_LAT);
      q.push_back(e);
      tick();
   endtask

   // release reset and count cycles until ready, checking outputs stay quiet
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      reset = 1'b0;
      while (ready !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (ready !== 1'b1) begin
            chk({tag, "_init_err"}, 32'(err), 32'd0);
            chk({tag, "_init_wrcnt"}, 32'(wr_cnt), 32'd0);
            chk({tag, "_init_rdcnt"}, 32'(rd_cnt), 32'd0);
         end
      end
      chk({tag, "_ready_latency"}, 32'(n), 32'(DEPTH));
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);

      wait_ready("boot");

      // write then read same address on the next cycle
      do_write(32'd3, 32'hDEADBEEF);
      do_read(32'd3, 32'hDEADBEEF, 1'b0);
      idle();
      tick(); tick(); tick();
      chk("wr_cnt_1", 32'(wr_cnt), 32'd1);
      chk("rd_cnt_1", 32'(rd_cnt), 32'd1);

      // never-written location
      do_read(32'd5, 32'd0, 1'b1);
      idle();
      tick(); tick(); tick();

      // back-to-back writes then back-to-back reads
      do_write(32'd0, 32'd10);
      do_write(32'd1, 32'd11);
      do_write(32'd2, 32'd12);
      do_read(32'd0, 32'd10, 1'b0);
      do_read(32'd1, 32'd11, 1'b0);
      do_read(32'd2, 32'd12, 1'b0);
      idle();
      tick(); tick(); tick();
      chk("wr_cnt_4", 32'(wr_cnt), 32'd4);
      chk("rd_cnt_5", 32'(rd_cnt), 32'd5);

      // conflicting request, then out-of-range read
      write = 1'b1; read = 1'b1; addr = 32'd2; wdata = 32'h1234_5678;
      tick();
      chk("err_both", 32'(err), 32'd1);
      write = 1'b0; read = 1'b1; addr = 32'd16;
      tick();
      chk("err_oob", 32'(err), 32'd1);
      write = 1'b1; read = 1'b0; addr = 32'hFFFF_FFF2; wdata = 32'h5;
      tick();
      chk("err_oob_wr", 32'(err), 32'd1);
      idle();
      tick();
      chk("err_clear", 32'(err), 32'd0);
      tick(); tick();
      chk("wr_cnt_hold", 32'(wr_cnt), 32'd4);
      chk("rd_cnt_hold", 32'(rd_cnt), 32'd5);
      do_read(32'd2, 32'd12, 1'b0);

      // write landing while older reads are still in flight
      do_read(32'd15, 32'd0, 1'b1);
      do_write(32'd15, 32'hA5A5_0F0F);
      do_read(32'd15, 32'hA5A5_0F0F, 1'b0);
      do_read(32'd3, 32'hDEADBEEF, 1'b0);
      idle();
      tick(); tick(); tick();
      chk("wr_cnt_5", 32'(wr_cnt), 32'd5);
      chk("rd_cnt_9", 32'(rd_cnt), 32'd9);

      // accepted read flushed by reset on the following cycle
      write = 1'b0; read = 1'b1; addr = 32'd7;
      tick();
      idle();
      reset = 1'b1;
      tick();
      chk("flush_ready", 32'(ready), 32'd0);
      chk("flush_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("flush_rd_cnt", 32'(rd_cnt), 32'd0);

      // reset again mid-clear, requests driven during clear must be ignored
      reset = 1'b0;
      write = 1'b1; read = 1'b0; addr = 32'd3; wdata = 32'h7777_7777;
      tick(); tick(); tick(); tick(); tick();
      chk("midinit_ready", 32'(ready), 32'd0);
      reset = 1'b1;
      tick();
      write = 1'b1; read = 1'b1; addr = 32'd40;
      wait_ready("restart");
      idle();
      tick();
      chk("post_err", 32'(err), 32'd0);
      chk("post_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("post_rd_cnt", 32'(rd_cnt), 32'd0);
      do_read(32'd3, 32'd0, 1'b1);
      idle();
      tick(); tick(); tick();
      chk("post_rd_cnt_1", 32'(rd_cnt), 32'd1);
      chk("sb_drain", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
